arq_send_controller: RTL and testbench
======================================

ARQ_SEND_CONTROLLER -- requirements
Module: arq_send_controller

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- ADDR_WIDTH, 10, address width.
- DFX_WIDTH, 2, router ID width; NUM_ROUTERS = 2**DFX_WIDTH.
- SEQ_NUM_WIDTH, 1, sequence-number width; arithmetic is modulo 2**SEQ_NUM_WIDTH.
- TIMEOUT_CYCLES, 256, ACK wait window in clk cycles; legal range 2..2**TIMER_WIDTH-1.
- TIMER_WIDTH, 16, timeout counter width.
- TTL_MAX, 2, maximum number of retransmissions after the first send.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, single clock; everything is rising-edge.
- rst_n, in, 1, asynchronous active-low reset.
- router_start_req, in, 1, send request; a rising edge starts a transaction.
- router_src_addr / router_dst_addr, in, ADDR_WIDTH, data addresses.
- router_src_dfx / router_dst_dfx, in, DFX_WIDTH, source and destination router IDs.
- router_send_done, out, 1, one-cycle pulse on ACK success.
- router_send_fail, out, 1, one-cycle pulse when retries are exhausted.
- busy, out, 1, high whenever state is not IDLE.
- start_get_data, out, 1, fetch start pulse.
- v_src_addr / v_dst_addr, out, ADDR_WIDTH, fetch addresses.
- done_get_data, in, 1, fetch complete.
- valid_ack_pkt, in, 1, ACK strobe.
- rn_ack_pkt, in, SEQ_NUM_WIDTH, request number from the ACK.
- src_dfx_ack_pkt, in, DFX_WIDTH, ACK sender ID.
- start_encap_pkt, out, 1, encapsulation start pulse.
- pkt_src_dfx / pkt_dst_dfx, out, DFX_WIDTH, header router IDs.
- pkt_sn, out, SEQ_NUM_WIDTH, header sequence number.
- done_encap_pkt, in, 1, encapsulation complete.
- start_frag_pkt, out, 1, fragmentation start pulse.
- frag_pkt_done, in, 1, fragmentation complete.

Function
REQ-003 The state machine SHALL have the states IDLE, GET_DATA, ENCAP, FRAG, WAIT_ACK, DONE and FAIL.
REQ-004 In IDLE, a request SHALL be recognised on router_start_req high with its previous-cycle registered value low; on that cycle the block SHALL capture all four request fields and go to GET_DATA. Request edges in any other state SHALL be ignored, with no queuing.
REQ-005 start_get_data, start_encap_pkt and start_frag_pkt SHALL each be registered and high for exactly one cycle, namely the first cycle current_state equals GET_DATA, ENCAP or FRAG respectively.
REQ-006 v_src_addr, v_dst_addr, pkt_src_dfx, pkt_dst_dfx and pkt_sn SHALL hold the captured values from state entry until return to IDLE, and SHALL be 0 in IDLE.
REQ-007 Completion inputs SHALL be sampled only in their own state, including the cycle the start pulse is high: done_get_data moves GET_DATA to ENCAP, done_encap_pkt moves ENCAP to FRAG, and frag_pkt_done moves FRAG to WAIT_ACK. A done input outside its state SHALL be ignored.
REQ-008 The block SHALL keep a per-destination send table sn_tbl[NUM_ROUTERS], reset to 0; pkt_sn SHALL equal sn_tbl[dst] at ENCAP entry.
REQ-009 An ACK SHALL be accepted only in WAIT_ACK, with valid_ack_pkt=1, src_dfx_ack_pkt equal to the captured dst_dfx, and rn_ack_pkt equal to (pkt_sn+1) mod 2**SEQ_NUM_WIDTH. All other ACKs (wrong source, stale RN, or arriving outside WAIT_ACK) SHALL be discarded without side effects.
REQ-010 On an accepted ACK the block SHALL set sn_tbl[dst] <= pkt_sn+1 with wrap and go to DONE. DONE SHALL last one cycle with router_send_done=1, then go to IDLE.
REQ-011 The timer SHALL clear on WAIT_ACK entry and increment each WAIT_ACK cycle. A timeout SHALL occur on the cycle the timer equals TIMEOUT_CYCLES-1 with no accepted ACK; an accepted ACK on that same cycle SHALL win.
REQ-012 On timeout with retry_cnt < TTL_MAX, the block SHALL increment retry_cnt and re-enter ENCAP with the same pkt_sn, issuing a new start_encap_pkt pulse; GET_DATA SHALL NOT be repeated.
REQ-013 On timeout with retry_cnt == TTL_MAX, the block SHALL go to FAIL. FAIL SHALL last one cycle with router_send_fail=1 and sn_tbl unchanged, then go to IDLE.
REQ-014 retry_cnt SHALL have width clog2(TTL_MAX+1) and be cleared on request capture. With TTL_MAX=0 there SHALL be no retransmission.
REQ-015 A request edge that lands on the DONE or FAIL cycle SHALL be ignored.

Reset
REQ-016 While rst_n=0, asynchronously: state SHALL be IDLE, and all outputs, sn_tbl, timer, retry_cnt, captured fields and the request-edge register SHALL be 0.
REQ-017 Reset mid-transaction SHALL abort the transaction with no done or fail pulse. A router_start_req held high through reset release SHALL NOT start a transaction until it goes low and then high again.

Verification
REQ-018 Single send: dst=2, every done input returned one cycle after its start pulse, ACK src=2 rn=1 -> pkt_sn=0, one router_send_done pulse, sn_tbl[2]=1; a second send to dst=2 carries pkt_sn=1.
REQ-019 Timeout retry: TIMEOUT_CYCLES=8, TTL_MAX=2, first ACK withheld -> start_encap_pkt re-pulses 8 cycles after WAIT_ACK entry, pkt_sn unchanged, start_get_data pulses only once; an ACK on the retry -> done pulse.
REQ-020 Exhaustion: no ACK -> exactly 3 start_encap_pkt pulses, then a router_send_fail pulse, sn_tbl[dst] unchanged, busy low the next cycle.
REQ-021 Filtering: ACK from src=1 while dst=3, and ACK with stale rn=0 -> both ignored and the timer keeps running; a correct ACK on the exact timeout cycle -> done, no retry.
REQ-022 Independence and protocol: alternate sends to dst 0 and 1 -> each table entry toggles independently; a request edge while busy is dropped; a request held high across rst_n release starts nothing.

Source files
------------

// File: rtl/arq_send_controller.sv
//------------------------------------------------------------------------------
// arq_send_controller
//   Stop-and-wait ARQ sender: fetch, encapsulate, fragment, then await a
//   matching ACK with timeout-driven retransmission and per-destination SN.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module arq_send_controller #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DFX_WIDTH      = 2,
  parameter int SEQ_NUM_WIDTH  = 1,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TIMER_WIDTH    = 16,
  parameter int TTL_MAX        = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     router_start_req,
  input  logic [ADDR_WIDTH-1:0]    router_src_addr,
  input  logic [ADDR_WIDTH-1:0]    router_dst_addr,
  input  logic [DFX_WIDTH-1:0]     router_src_dfx,
  input  logic [DFX_WIDTH-1:0]     router_dst_dfx,
  output logic                     router_send_done,
  output logic                     router_send_fail,
  output logic                     busy,
  output logic                     start_get_data,
  output logic [ADDR_WIDTH-1:0]    v_src_addr,
  output logic [ADDR_WIDTH-1:0]    v_dst_addr,
  input  logic                     done_get_data,
  input  logic                     valid_ack_pkt,
  input  logic [SEQ_NUM_WIDTH-1:0] rn_ack_pkt,
  input  logic [DFX_WIDTH-1:0]     src_dfx_ack_pkt,
  output logic                     start_encap_pkt,
  output logic [DFX_WIDTH-1:0]     pkt_src_dfx,
  output logic [DFX_WIDTH-1:0]     pkt_dst_dfx,
  output logic [SEQ_NUM_WIDTH-1:0] pkt_sn,
  input  logic                     done_encap_pkt,
  output logic                     start_frag_pkt,
  input  logic                     frag_pkt_done
);

  localparam int NUM_ROUTERS = 2**DFX_WIDTH;
  localparam int RETRY_W     = (TTL_MAX > 0) ? $clog2(TTL_MAX + 1) : 1;
  localparam logic [RETRY_W-1:0]       RETRY_MAX  = RETRY_W'(TTL_MAX);
  localparam logic [TIMER_WIDTH-1:0]   TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [SEQ_NUM_WIDTH-1:0] SN_ONE     = SEQ_NUM_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_DATA = 3'd1,
    ENCAP    = 3'd2,
    FRAG     = 3'd3,
    WAIT_ACK = 3'd4,
    DONE     = 3'd5,
    FAIL     = 3'd6
  } state_t;

  state_t                   state_q, state_d;
  logic                     req_prev_q, req_prev_d;
  logic                     armed_q, armed_d;
  logic [ADDR_WIDTH-1:0]    src_addr_q, src_addr_d;
  logic [ADDR_WIDTH-1:0]    dst_addr_q, dst_addr_d;
  logic [DFX_WIDTH-1:0]     src_dfx_q, src_dfx_d;
  logic [DFX_WIDTH-1:0]     dst_dfx_q, dst_dfx_d;
  logic [SEQ_NUM_WIDTH-1:0] sn_q, sn_d;
  logic [TIMER_WIDTH-1:0]   timer_q, timer_d;
  logic [RETRY_W-1:0]       retry_q, retry_d;
  logic                     start_get_q, start_get_d;
  logic                     start_encap_q, start_encap_d;
  logic                     start_frag_q, start_frag_d;
  logic [SEQ_NUM_WIDTH-1:0] sn_tbl_q [NUM_ROUTERS];
  logic [SEQ_NUM_WIDTH-1:0] sn_tbl_d [NUM_ROUTERS];

  logic                     req_edge;
  logic                     ack_ok;
  logic                     timeout;
  logic [SEQ_NUM_WIDTH-1:0] sn_next;

  // armed_q blocks a request held high across reset release until it drops.
  assign req_edge = router_start_req && !req_prev_q && armed_q;
  assign sn_next  = sn_q + SN_ONE;
  assign ack_ok   = valid_ack_pkt && (src_dfx_ack_pkt == dst_dfx_q) && (rn_ack_pkt == sn_next);
  assign timeout  = (timer_q == TIMER_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (req_edge)       state_d = GET_DATA;
      GET_DATA: if (done_get_data)  state_d = ENCAP;
      ENCAP:    if (done_encap_pkt) state_d = FRAG;
      FRAG:     if (frag_pkt_done)  state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (ack_ok)                  state_d = DONE;
        else if (timeout) begin
          if (retry_q < RETRY_MAX)   state_d = ENCAP;
          else                       state_d = FAIL;
        end
      end
      DONE:     state_d = IDLE;
      FAIL:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    req_prev_d    = router_start_req;
    armed_d       = armed_q || !router_start_req;
    src_addr_d    = src_addr_q;
    dst_addr_d    = dst_addr_q;
    src_dfx_d     = src_dfx_q;
    dst_dfx_d     = dst_dfx_q;
    sn_d          = sn_q;
    timer_d       = timer_q;
    retry_d       = retry_q;
    sn_tbl_d      = sn_tbl_q;
    start_get_d   = (state_d == GET_DATA) && (state_q != GET_DATA);
    start_encap_d = (state_d == ENCAP)    && (state_q != ENCAP);
    start_frag_d  = (state_d == FRAG)     && (state_q != FRAG);

    // The table entry cannot change before ENCAP, so SN is latched with the request.
    if (state_q == IDLE && req_edge) begin
      src_addr_d = router_src_addr;
      dst_addr_d = router_dst_addr;
      src_dfx_d  = router_src_dfx;
      dst_dfx_d  = router_dst_dfx;
      sn_d       = sn_tbl_q[router_dst_dfx];
      retry_d    = '0;
    end else if (state_d == IDLE) begin
      src_addr_d = '0;
      dst_addr_d = '0;
      src_dfx_d  = '0;
      dst_dfx_d  = '0;
      sn_d       = '0;
    end

    if (state_q == WAIT_ACK) begin
      timer_d = timer_q + 1'b1;
      if (ack_ok)
        sn_tbl_d[dst_dfx_q] = sn_next;
      else if (timeout && (retry_q < RETRY_MAX))
        retry_d = retry_q + 1'b1;
    end
    if (state_d == WAIT_ACK && state_q != WAIT_ACK)
      timer_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      req_prev_q    <= 1'b0;
      armed_q       <= 1'b0;
      src_addr_q    <= '0;
      dst_addr_q    <= '0;
      src_dfx_q     <= '0;
      dst_dfx_q     <= '0;
      sn_q          <= '0;
      timer_q       <= '0;
      retry_q       <= '0;
      start_get_q   <= 1'b0;
      start_encap_q <= 1'b0;
      start_frag_q  <= 1'b0;
      for (int i = 0; i < NUM_ROUTERS; i++) sn_tbl_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      req_prev_q    <= req_prev_d;
      armed_q       <= armed_d;
      src_addr_q    <= src_addr_d;
      dst_addr_q    <= dst_addr_d;
      src_dfx_q     <= src_dfx_d;
      dst_dfx_q     <= dst_dfx_d;
      sn_q          <= sn_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      start_get_q   <= start_get_d;
      start_encap_q <= start_encap_d;
      start_frag_q  <= start_frag_d;
      sn_tbl_q      <= sn_tbl_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign router_send_done = (state_q == DONE);
  assign router_send_fail = (state_q == FAIL);
  assign start_get_data   = start_get_q;
  assign start_encap_pkt  = start_encap_q;
  assign start_frag_pkt   = start_frag_q;
  assign v_src_addr       = src_addr_q;
  assign v_dst_addr       = dst_addr_q;
  assign pkt_src_dfx      = src_dfx_q;
  assign pkt_dst_dfx      = dst_dfx_q;
  assign pkt_sn           = sn_q;

endmodule

`default_nettype wire

// File: tb/tb_arq_send_controller.sv
//------------------------------------------------------------------------------
// tb_arq_send_controller
//   Directed self-checking bench for arq_send_controller (timeout 8, TTL 2).
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_arq_send_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       router_start_req = 1'b0;
  logic [9:0] router_src_addr = '0;
  logic [9:0] router_dst_addr = '0;
  logic [1:0] router_src_dfx = '0;
  logic [1:0] router_dst_dfx = '0;
  logic       router_send_done, router_send_fail, busy;
  logic       start_get_data, start_encap_pkt, start_frag_pkt;
  logic [9:0] v_src_addr, v_dst_addr;
  logic       done_get_data = 1'b0;
  logic       valid_ack_pkt = 1'b0;
  logic [0:0] rn_ack_pkt = '0;
  logic [1:0] src_dfx_ack_pkt = '0;
  logic [1:0] pkt_src_dfx, pkt_dst_dfx;
  logic [0:0] pkt_sn;
  logic       done_encap_pkt = 1'b0;
  logic       frag_pkt_done = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;
  int n_get = 0, n_encap = 0, n_done = 0, n_failp = 0;

  arq_send_controller #(
    .ADDR_WIDTH(10), .DFX_WIDTH(2), .SEQ_NUM_WIDTH(1),
    .TIMEOUT_CYCLES(8), .TIMER_WIDTH(16), .TTL_MAX(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .router_start_req(router_start_req),
    .router_src_addr(router_src_addr), .router_dst_addr(router_dst_addr),
    .router_src_dfx(router_src_dfx), .router_dst_dfx(router_dst_dfx),
    .router_send_done(router_send_done), .router_send_fail(router_send_fail),
    .busy(busy), .start_get_data(start_get_data),
    .v_src_addr(v_src_addr), .v_dst_addr(v_dst_addr),
    .done_get_data(done_get_data), .valid_ack_pkt(valid_ack_pkt),
    .rn_ack_pkt(rn_ack_pkt), .src_dfx_ack_pkt(src_dfx_ack_pkt),
    .start_encap_pkt(start_encap_pkt),
    .pkt_src_dfx(pkt_src_dfx), .pkt_dst_dfx(pkt_dst_dfx), .pkt_sn(pkt_sn),
    .done_encap_pkt(done_encap_pkt), .start_frag_pkt(start_frag_pkt),
    .frag_pkt_done(frag_pkt_done)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (start_get_data)   n_get++;
    if (start_encap_pkt)  n_encap++;
    if (router_send_done) n_done++;
    if (router_send_fail) n_failp++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue a request edge; returns on the first GET_DATA cycle.
  task automatic start_req(input logic [1:0] dst, input logic [9:0] sa, input logic [9:0] da);
    router_src_addr  = sa;
    router_dst_addr  = da;
    router_src_dfx   = 2'd1;
    router_dst_dfx   = dst;
    router_start_req = 1'b1;
    step(1);
    router_start_req = 1'b0;
    check_eq("busy_on_start", busy, 1);
    check_eq("get_pulse", start_get_data, 1);
    check_eq("v_src_addr", v_src_addr, sa);
    check_eq("v_dst_addr", v_dst_addr, da);
    check_eq("pkt_dst_dfx", pkt_dst_dfx, dst);
  endtask

  task automatic through_get();
    step(1);
    check_eq("get_pulse_one_cycle", start_get_data, 0);
    done_get_data = 1'b1;
    step(1);
    done_get_data = 1'b0;
  endtask

  // Entered on the first ENCAP cycle; leaves on the first WAIT_ACK cycle.
  task automatic through_encap_frag(input logic [0:0] exp_sn);
    check_eq("encap_pulse", start_encap_pkt, 1);
    check_eq("pkt_sn", pkt_sn, exp_sn);
    step(1);
    done_encap_pkt = 1'b1;
    step(1);
    done_encap_pkt = 1'b0;
    check_eq("frag_pulse", start_frag_pkt, 1);
    step(1);
    frag_pkt_done = 1'b1;
    step(1);
    frag_pkt_done = 1'b0;
  endtask

  task automatic ack(input logic [1:0] src, input logic [0:0] rn);
    valid_ack_pkt   = 1'b1;
    src_dfx_ack_pkt = src;
    rn_ack_pkt      = rn;
    step(1);
    valid_ack_pkt = 1'b0;
  endtask

  task automatic expect_done();
    check_eq("done_pulse", router_send_done, 1);
    step(1);
    check_eq("done_then_idle", busy, 0);
    check_eq("done_one_cycle", router_send_done, 0);
    check_eq("idle_addr_zero", v_src_addr, 0);
  endtask

  task automatic send_ok(input logic [1:0] dst, input logic [0:0] exp_sn);
    start_req(dst, 10'h05A, 10'h1C3);
    through_get();
    through_encap_frag(exp_sn);
    ack(dst, exp_sn + 1'b1);
    expect_done();
  endtask

  initial begin
    int e0, g0, f0, d0;

    // Reset state
    step(2);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", router_send_done, 0);
    check_eq("rst_fail", router_send_fail, 0);
    check_eq("rst_pkt_sn", pkt_sn, 0);
    check_eq("rst_start_get", start_get_data, 0);
    rst_n = 1'b1;
    step(2);

    // Single send to dst 2, then a second send carries the advanced SN
    d0 = n_done;
    send_ok(2'd2, 1'b0);
    check_eq("single_done_count", n_done - d0, 1);
    send_ok(2'd2, 1'b1);

    // Filtering: wrong source and stale RN ignored; ACK on the timeout cycle wins
    e0 = n_encap;
    start_req(2'd3, 10'h011, 10'h022);
    through_get();
    through_encap_frag(1'b0);
    ack(2'd1, 1'b1);
    check_eq("wrong_src_ignored", router_send_done, 0);
    ack(2'd3, 1'b0);
    check_eq("stale_rn_ignored", router_send_done, 0);
    step(5);
    ack(2'd3, 1'b1);
    check_eq("ack_on_timeout_no_retry", start_encap_pkt, 0);
    expect_done();
    check_eq("filter_encap_count", n_encap - e0, 1);

    // Timeout retry on dst 3 (SN now 1)
    e0 = n_encap;
    g0 = n_get;
    start_req(2'd3, 10'h100, 10'h200);
    through_get();
    through_encap_frag(1'b1);
    step(7);
    check_eq("no_early_retry", start_encap_pkt, 0);
    step(1);
    through_encap_frag(1'b1);
    ack(2'd3, 1'b0);
    expect_done();
    check_eq("retry_get_once", n_get - g0, 1);
    check_eq("retry_encap_twice", n_encap - e0, 2);

    // Exhaustion on dst 0
    e0 = n_encap;
    f0 = n_failp;
    d0 = n_done;
    start_req(2'd0, 10'h3FF, 10'h001);
    through_get();
    for (int r = 0; r < 3; r++) begin
      through_encap_frag(1'b0);
      step(7);
      check_eq("exh_waiting_busy", busy, 1);
      check_eq("exh_no_early_fail", router_send_fail, 0);
      step(1);
    end
    check_eq("exh_fail_pulse", router_send_fail, 1);
    step(1);
    check_eq("exh_busy_low", busy, 0);
    check_eq("exh_fail_one_cycle", router_send_fail, 0);
    check_eq("exh_encap_count", n_encap - e0, 3);
    check_eq("exh_fail_count", n_failp - f0, 1);
    check_eq("exh_no_done", n_done - d0, 0);

    // Independence: dst 0 SN was left unchanged by the failure
    send_ok(2'd0, 1'b0);
    send_ok(2'd1, 1'b0);
    send_ok(2'd0, 1'b1);

    // Request edge while busy is dropped
    start_req(2'd1, 10'h0AA, 10'h0BB);
    through_get();
    through_encap_frag(1'b1);
    router_start_req = 1'b1;
    step(1);
    router_start_req = 1'b0;
    ack(2'd1, 1'b0);
    expect_done();
    step(2);
    check_eq("busy_edge_dropped", busy, 0);

    // Request edge landing on the DONE cycle is dropped
    start_req(2'd1, 10'h0AA, 10'h0BB);
    through_get();
    through_encap_frag(1'b0);
    ack(2'd1, 1'b1);
    router_start_req = 1'b1;
    check_eq("done_cycle_pulse", router_send_done, 1);
    step(1);
    check_eq("done_edge_dropped_a", busy, 0);
    step(1);
    check_eq("done_edge_dropped_b", busy, 0);
    router_start_req = 1'b0;
    step(1);

    // Mid-transaction reset with request held high across release
    d0 = n_done;
    f0 = n_failp;
    start_req(2'd1, 10'h123, 10'h321);
    through_get();
    router_start_req = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_encap", start_encap_pkt, 0);
    check_eq("async_rst_addr", v_src_addr, 0);
    step(2);
    rst_n = 1'b1;
    step(3);
    check_eq("held_req_no_start", busy, 0);
    check_eq("abort_no_done", n_done - d0, 0);
    check_eq("abort_no_fail", n_failp - f0, 0);
    router_start_req = 1'b0;
    step(1);
    send_ok(2'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
